// File: rtl/neighbor_link_ctx_pkg.sv
// neighbor_link_ctx_pkg
// Shared definitions for the multi-context neighbour link:
//   - STAGE_* encodings of the array-wide global stage and STAGE_WIDTH
//   - boundary-condition constants (BC_NORMAL / BC_BOUNDARY / BC_NONE)
//   - ctx_state_t, the context-switch FSM state enum
//   - sanitize_bc(), which folds the reserved code 3 onto BC_NONE
package neighbor_link_ctx_pkg;

    localparam int STAGE_WIDTH = 3;

    localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE                = 3'd0;
    localparam logic [STAGE_WIDTH-1:0] STAGE_PARAMETERS_LOADING  = 3'd1;
    localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_LOADING = 3'd2;
    localparam logic [STAGE_WIDTH-1:0] STAGE_GROW                = 3'd3;
    localparam logic [STAGE_WIDTH-1:0] STAGE_MERGE               = 3'd4;
    localparam logic [STAGE_WIDTH-1:0] STAGE_PEELING             = 3'd5;
    localparam logic [STAGE_WIDTH-1:0] STAGE_RESULT_VALID        = 3'd6;

    localparam logic [1:0] BC_NORMAL   = 2'd0;
    localparam logic [1:0] BC_BOUNDARY = 2'd1;
    localparam logic [1:0] BC_NONE     = 2'd2;

    typedef enum logic [1:0] {
        CTX_IDLE = 2'd0,
        CTX_SAVE = 2'd1,
        CTX_READ = 2'd2,
        CTX_LOAD = 2'd3
    } ctx_state_t;

    // The reserved code 3 behaves exactly like a nonexistent edge, so it is
    // folded onto BC_NONE at capture time and never reaches the live state.
    function automatic logic [1:0] sanitize_bc(input logic [1:0] bc);
        return bc[1] ? BC_NONE : bc;
    endfunction

endpackage

// File: rtl/neighbor_link_ctx_ram.sv
// rams_sp_nc
// Single-port synchronous-read RAM in no-change mode: during a write the
// read register keeps its previous value. Contents are not reset.
// Ports:
//   clk   in   1      clock
//   we    in   1      write enable
//   addr  in   AW     word address
//   din   in   WIDTH  write data
//   dout  out  WIDTH  registered read data
module rams_sp_nc #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end else begin
            dout <= mem[addr];
        end
    end

endmodule

// File: rtl/neighbor_link_ctx.sv
// neighbor_link_ctx
// Edge between two neighbouring processing units. Tracks growth, error and
// boundary state of one edge for NUM_CONTEXTS independent contexts. The live
// context sits in flops; parked contexts sit in rams_sp_nc. A req/ack
// handshake swaps contexts, optionally saving the live one first.
// Optional feature macro: LINK_CTX_PARITY_EN (even parity on each RAM word,
// sticky parity_err on a failed load). Without it parity_err is tied to 0.
// Ports:
//   clk, reset (async, active-low)
//   global_stage                 array stage (registered here, 1-cycle delay)
//   a_/b_increase                growth requests from side A/B
//   a_/b_input_data              exposed data from A/B
//   a_/b_output_data             cross-forwarded data, 0 unless bc==0
//   a_/b_is_error_in             error marks from A/B
//   is_error_systolic_in         systolic error, used in STAGE_RESULT_VALID
//   weight_in, boundary_condition_in   captured in STAGE_PARAMETERS_LOADING
//   ctx_req, ctx_id, ctx_store   context-switch request
//   ctx_busy, ctx_ack, cur_ctx   switch status
//   fully_grown, is_boundary, is_error, weight_out, boundary_condition_out
//   parity_err                   sticky parity error
module neighbor_link_ctx
    import neighbor_link_ctx_pkg::*;
#(
    parameter  int ADDRESS_WIDTH = 6,
    parameter  int MAX_WEIGHT    = 2,
    parameter  int NUM_CONTEXTS  = 4,
    localparam int LBW           = $clog2(MAX_WEIGHT + 1),
    localparam int CW            = $clog2(NUM_CONTEXTS),
    localparam int DW            = ADDRESS_WIDTH + 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [STAGE_WIDTH-1:0] global_stage,
    input  logic                   a_increase,
    input  logic                   b_increase,
    input  logic [DW-1:0]          a_input_data,
    input  logic [DW-1:0]          b_input_data,
    output logic [DW-1:0]          a_output_data,
    output logic [DW-1:0]          b_output_data,
    input  logic                   a_is_error_in,
    input  logic                   b_is_error_in,
    input  logic                   is_error_systolic_in,
    input  logic [LBW-1:0]         weight_in,
    input  logic [1:0]             boundary_condition_in,
    input  logic                   ctx_req,
    input  logic [CW-1:0]          ctx_id,
    input  logic                   ctx_store,
    output logic                   ctx_busy,
    output logic                   ctx_ack,
    output logic [CW-1:0]          cur_ctx,
    output logic                   fully_grown,
    output logic                   is_boundary,
    output logic                   is_error,
    output logic [LBW-1:0]         weight_out,
    output logic [1:0]             boundary_condition_out,
    output logic                   parity_err
);

`ifdef LINK_CTX_PARITY_EN
    localparam int PW = 1;
`else
    localparam int PW = 0;
`endif
    localparam int PAYLOAD_W = 2 + 2 * LBW + 1;
    localparam int RAM_W     = PAYLOAD_W + PW;
    localparam int GCW       = LBW + 1;

    logic [STAGE_WIDTH-1:0]  stage;
    ctx_state_t              state;
    logic [CW-1:0]           ctx_id_q;
    logic [LBW-1:0]          growth;
    logic [NUM_CONTEXTS-1:0] valid;

    logic                    ram_we;
    logic [CW-1:0]           ram_addr;
    logic [RAM_W-1:0]        ram_din;
    logic [RAM_W-1:0]        ram_dout;
    logic [PAYLOAD_W-1:0]    live_word;
    logic [PAYLOAD_W-1:0]    load_word;
    logic                    parity_ok;
    logic                    load_ok;

    logic [GCW-1:0]          growth_calc;
    logic [LBW-1:0]          growth_next;
    logic                    error_next;

    // The stage is broadcast across the array, so it is retimed once here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage <= STAGE_IDLE;
        end else begin
            stage <= global_stage;
        end
    end

    // Context-switch sequencer. The target id is latched with the request so
    // the requester may change ctx_id afterwards; requests while busy drop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= CTX_IDLE;
            ctx_id_q <= '0;
            cur_ctx  <= '0;
            ctx_ack  <= 1'b0;
        end else begin
            ctx_ack <= 1'b0;
            case (state)
                CTX_IDLE: begin
                    if (ctx_req) begin
                        ctx_id_q <= ctx_id;
                        state    <= ctx_store ? CTX_SAVE : CTX_READ;
                    end
                end
                CTX_SAVE: state <= CTX_READ;
                CTX_READ: state <= CTX_LOAD;
                CTX_LOAD: begin
                    cur_ctx <= ctx_id_q;
                    ctx_ack <= 1'b1;
                    state   <= CTX_IDLE;
                end
                default:  state <= CTX_IDLE;
            endcase
        end
    end

    assign ctx_busy = (state != CTX_IDLE);

    // The RAM port points at the live context only while it is being saved.
    assign ram_we    = (state == CTX_SAVE);
    assign ram_addr  = ram_we ? cur_ctx : ctx_id_q;
    assign live_word = {boundary_condition_out, weight_out, growth, is_error};
    assign load_word = ram_dout[PAYLOAD_W-1:0];

`ifdef LINK_CTX_PARITY_EN
    assign ram_din   = {^live_word, live_word};
    assign parity_ok = ~^ram_dout;
`else
    assign ram_din   = live_word;
    assign parity_ok = 1'b1;
`endif

    // A context that was never parameterised or saved loads as nonexistent.
    assign load_ok = valid[ctx_id_q] && parity_ok;

    rams_sp_nc #(
        .DEPTH (NUM_CONTEXTS),
        .WIDTH (RAM_W)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (ram_addr),
        .din  (ram_din),
        .dout (ram_dout)
    );

    // Growth is summed one bit wider than the weight so that two increments
    // on a nearly full edge cannot wrap before the saturation compare.
    always_comb begin
        growth_calc = '0;
        error_next  = 1'b0;
        case (boundary_condition_out)
            BC_NORMAL: begin
                growth_calc = {1'b0, growth} + GCW'(a_increase) + GCW'(b_increase);
                error_next  = a_is_error_in | b_is_error_in;
            end
            BC_BOUNDARY: begin
                growth_calc = {1'b0, growth} + GCW'(a_increase);
                error_next  = a_is_error_in;
            end
            default: begin
                growth_calc = '0;
                error_next  = 1'b0;
            end
        endcase
        if (stage == STAGE_RESULT_VALID) begin
            error_next = is_error_systolic_in;
        end
        growth_next = (growth_calc > {1'b0, weight_out}) ? weight_out : growth_calc[LBW-1:0];
    end

    // Live edge state. LOAD overrides everything, SAVE marks the context as
    // holding real data, and stage-driven updates only run while idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            growth                 <= '0;
            is_error               <= 1'b0;
            weight_out             <= '0;
            boundary_condition_out <= BC_NONE;
            valid                  <= '0;
        end else if (state == CTX_LOAD) begin
            if (load_ok) begin
                {boundary_condition_out, weight_out, growth, is_error} <= load_word;
            end else begin
                boundary_condition_out <= BC_NONE;
                weight_out             <= '0;
                growth                 <= '0;
                is_error               <= 1'b0;
            end
        end else if (state == CTX_SAVE) begin
            valid[cur_ctx] <= 1'b1;
        end else if (state == CTX_IDLE) begin
            if (stage == STAGE_MEASUREMENT_LOADING) begin
                growth   <= '0;
                is_error <= 1'b0;
            end else begin
                growth   <= growth_next;
                is_error <= error_next;
            end
            if (stage == STAGE_PARAMETERS_LOADING) begin
                weight_out             <= weight_in;
                boundary_condition_out <= sanitize_bc(boundary_condition_in);
                valid[cur_ctx]         <= 1'b1;
            end
        end
    end

`ifdef LINK_CTX_PARITY_EN
    // Only words marked valid are checked; untouched RAM holds garbage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parity_err <= 1'b0;
        end else if ((state == CTX_LOAD) && valid[ctx_id_q] && !parity_ok) begin
            parity_err <= 1'b1;
        end else if (stage == STAGE_MEASUREMENT_LOADING) begin
            parity_err <= 1'b0;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    // Nonexistent edges never count as grown, which also keeps fully_grown
    // low out of reset when weight and growth are both zero.
    assign fully_grown   = !boundary_condition_out[1] && (growth >= weight_out);
    assign is_boundary   = (boundary_condition_out == BC_BOUNDARY) && fully_grown;
    assign a_output_data = (boundary_condition_out == BC_NORMAL) ? b_input_data : '0;
    assign b_output_data = (boundary_condition_out == BC_NORMAL) ? a_input_data : '0;

endmodule
